lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between execute stage and data-memory port of the RV32 core.
//  Accepts one LOAD/STORE op at a time and drives a req/gnt + rvalid memory handshake.
//  Decodes funct3 into byte enables and write-data lane replication.
//  Returns sign/zero-extended load data to writeback and flags misaligned, illegal-width and timeout errors.
// PARAMETERS
//  ADDR_W          32   byte-address width
//  TIMEOUT_CYCLES  255  max cycles in WAIT for rvalid; 0 = no timeout; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk_i          in   1       core clock
//  rst_ni         in   1       asynchronous active-low reset
//  ex_valid_i     in   1       op presented by execute
//  ex_ready_o     out  1       LSU idle, can accept
//  ex_store_i     in   1       1 = STORE, 0 = LOAD
//  ex_funct3_i    in   3       ld_op_t / sd_op_t encoding
//  ex_addr_i      in   ADDR_W  effective byte address
//  ex_wdata_i     in   32      store data (rs2)
//  ex_rd_i        in   5       load destination register
//  mem_req_o      out  1       memory request
//  mem_gnt_i      in   1       request accepted
//  mem_we_o       out  1       write enable
//  mem_be_o       out  4       byte enables
//  mem_addr_o     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  mem_wdata_o    out  32      lane-replicated store data
//  mem_rvalid_i   in   1       response valid (loads and stores)
//  mem_rdata_i    in   32      read word
//  wb_we_o        out  1       1-cycle pulse: write wb_data_o to wb_rd_o
//  wb_rd_o        out  5       destination register
//  wb_data_o      out  32      extended load result
//  done_o         out  1       1-cycle pulse per completed op (load, store or error)
//  err_o          out  1       1-cycle pulse, coincident with done_o
//  err_cause_o    out  2       01 misaligned, 10 illegal funct3, 11 timeout; 00 otherwise
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, all outputs 0 except ex_ready_o=1. Reset mid-op abandons the access; rvalid arriving later in IDLE is ignored.
//  - ex_ready_o = (state==IDLE). Accept on ex_valid_i & ex_ready_o; op fields registered.
//  - FSM: IDLE -accept-> REQ; REQ -gnt-> WAIT; WAIT -rvalid-> IDLE. REQ with gnt & rvalid same cycle -> IDLE directly.
//  - Latency: mem_req_o high cycle after accept, held with addr/be/we/wdata stable until gnt.
//  - Min load-to-wb: accept N, req N+1, gnt N+1, rvalid N+2, wb_we_o/done_o N+3 (registered).
//  - Byte enables: B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111.
//  - wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  - Load extract: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
//  - Illegal funct3: load 011 (LD), 110 (LWU), 111; store 011..111. No mem request; done_o+err_o (10) cycle after accept.
//  - wb_we_o suppressed for rd=0 and for stores; done_o still pulses.
//  - Timeout: counter clears on REQ->WAIT, +1 per WAIT cycle; reaching TIMEOUT_CYCLES without rvalid -> IDLE, done_o+err_o (11), no wb.
//  - rvalid in IDLE or in REQ without gnt: ignored.
// CONFIGURATION
//  LSU_MISALIGN_EXC_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no mem request;
//    done_o+err_o (01) cycle after accept; FSM stays IDLE.
//  LSU_MISALIGN_EXC_EN undefined: no alignment check; H uses addr[1]*2 offset, W uses offset 0;
//    err_cause 01 never produced.
// TESTING
//  1. LW addr 0x104, rdata 0xDEADBEEF, gnt immediate, rvalid next -> be 1111, addr 0x104, wb_data 0xDEADBEEF, wb_we N+3.
//  2. LB addr 0x103 rdata 0x80XXXXXX -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 rdata 0xBEEFxxxx -> 0x0000BEEF.
//  3. SH addr 0x202 wdata 0x1234ABCD, gnt held low 3 cycles -> req/be 1100/wdata 0xABCDABCD stable until gnt; done_o, no wb_we_o.
//  4. LW rd=0 -> done_o pulses, wb_we_o stays 0; load funct3 011 -> err_cause 10, mem_req_o never asserted.
//  5. TIMEOUT_CYCLES=4, gnt, no rvalid -> err_cause 11 after 4 WAIT cycles; late rvalid ignored; next op accepted.
//  6. rst_ni low in WAIT, then rvalid -> all outputs 0, ex_ready_o=1, no wb_we_o/done_o; SW addr 0x101: macro on -> err 01, off -> be 1111 addr 0x100.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32 execute stage and a req/gnt + rvalid data-memory port.
// Optional build macro LSU_MISALIGN_EXC_EN: reject misaligned halfword/word accesses with cause 01.
module lsu_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              ex_store_i,
   input  logic [2:0]        ex_funct3_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [31:0]       ex_wdata_i,
   input  logic [4:0]        ex_rd_i,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              wb_we_o,
   output logic [4:0]        wb_rd_o,
   output logic [31:0]       wb_data_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_cause_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic TO_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_MISALGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // funct3[1:0] carries the access size for both loads and stores; H drops addr[0].
   function automatic logic [1:0] f_offset(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [1:0] off;
      case (size)
         2'b00:   off = addr_lo;
         2'b01:   off = {addr_lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

   function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         2'b00:   lanes = {4{wdata[7:0]}};
         2'b01:   lanes = {2{wdata[15:0]}};
         default: lanes = wdata;
      endcase
      return lanes;
   endfunction

   function automatic logic f_illegal(input logic store, input logic [2:0] funct3);
      logic bad;
      if (store) begin
         bad = funct3[2] | (funct3[1] & funct3[0]);
      end else begin
         bad = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
      end
      return bad;
   endfunction

   function automatic logic [31:0] f_load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                              input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] res;
      sh = rdata >> {off, 3'b000};
      case (funct3)
         3'b000:  res = {{24{sh[7]}}, sh[7:0]};
         3'b001:  res = {{16{sh[15]}}, sh[15:0]};
         3'b010:  res = rdata;
         3'b100:  res = {24'd0, sh[7:0]};
         3'b101:  res = {16'd0, sh[15:0]};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_cnt_inc;

   logic              r_store;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [4:0]        r_rd;
   logic              r_mem_we;
   logic [3:0]        r_mem_be;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;

   logic              r_wb_we;
   logic [4:0]        r_wb_rd;
   logic [31:0]       r_wb_data;
   logic              r_done;
   logic              r_err;
   logic [1:0]        r_cause;

   logic              w_accept;
   logic              w_illegal;
   logic              w_misaligned;
   logic [1:0]        w_off;
   logic              w_load_fields;
   logic              w_complete;
   logic              w_wb_we_nxt;
   logic [4:0]        w_wb_rd_nxt;
   logic [31:0]       w_wb_data_nxt;
   logic              w_done_nxt;
   logic              w_err_nxt;
   logic [1:0]        w_cause_nxt;

   assign w_accept  = ex_valid_i & (r_state == ST_IDLE);
   assign w_illegal = f_illegal(ex_store_i, ex_funct3_i);
   assign w_off     = f_offset(ex_funct3_i[1:0], ex_addr_i[1:0]);
   assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef LSU_MISALIGN_EXC_EN
   assign w_misaligned = ((ex_funct3_i[1:0] == 2'b01) & ex_addr_i[0]) |
                         ((ex_funct3_i[1:0] == 2'b10) & (ex_addr_i[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   // Next-state, timeout counter and completion/writeback decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_load_fields = 1'b0;
      w_complete    = 1'b0;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_cause_nxt   = CAUSE_NONE;
      w_wb_we_nxt   = 1'b0;
      w_wb_rd_nxt   = 5'd0;
      w_wb_data_nxt = 32'd0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_illegal) begin
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = 1'b1;
                  w_cause_nxt = CAUSE_ILLEGAL;
               end else if (w_misaligned) begin
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = 1'b1;
                  w_cause_nxt = CAUSE_MISALGN;
               end else begin
                  w_load_fields = 1'b1;
                  w_state_nxt   = ST_REQ;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            // A response without a grant cannot belong to this request.
            if (mem_gnt_i) begin
               w_cnt_nxt = {CNT_W{1'b0}};
               if (mem_rvalid_i) begin
                  w_complete  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               w_complete  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (TO_EN && (w_cnt_inc == CNT_MAX)) begin
               w_cnt_nxt   = w_cnt_inc;
               w_done_nxt  = 1'b1;
               w_err_nxt   = 1'b1;
               w_cause_nxt = CAUSE_TIMEOUT;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_complete) begin
         w_done_nxt = 1'b1;
         if (!r_store && (r_rd != 5'd0)) begin
            w_wb_we_nxt   = 1'b1;
            w_wb_rd_nxt   = r_rd;
            w_wb_data_nxt = f_load_ext(r_funct3, r_off, mem_rdata_i);
         end else begin
            w_wb_we_nxt = 1'b0;
         end
      end else begin
         w_complete = 1'b0;
      end
   end

   // FSM state and timeout counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Accepted op fields; memory-side values stay stable until the grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_store     <= 1'b0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_rd        <= 5'd0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'd0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= 32'd0;
      end else if (w_load_fields) begin
         r_store     <= ex_store_i;
         r_funct3    <= ex_funct3_i;
         r_off       <= w_off;
         r_rd        <= ex_rd_i;
         r_mem_we    <= ex_store_i;
         r_mem_be    <= f_be(ex_funct3_i[1:0], w_off);
         r_mem_addr  <= {ex_addr_i[ADDR_W-1:2], 2'b00};
         r_mem_wdata <= f_wdata(ex_funct3_i[1:0], ex_wdata_i);
      end
   end

   // Writeback and completion pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wb_we   <= 1'b0;
         r_wb_rd   <= 5'd0;
         r_wb_data <= 32'd0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_cause   <= CAUSE_NONE;
      end else begin
         r_wb_we   <= w_wb_we_nxt;
         r_wb_rd   <= w_wb_rd_nxt;
         r_wb_data <= w_wb_data_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_cause   <= w_cause_nxt;
      end
   end

   assign ex_ready_o  = (r_state == ST_IDLE);
   assign mem_req_o   = (r_state == ST_REQ);
   assign mem_we_o    = r_mem_we;
   assign mem_be_o    = r_mem_be;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign wb_we_o     = r_wb_we;
   assign wb_rd_o     = r_wb_rd;
   assign wb_data_o   = r_wb_data;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign err_cause_o = r_cause;

endmodule
